// File: rtl/light_board_ctrl_if.sv
// Mode/board-select link between the timer (master) and one board sequencer (slave).
// ped_req exists only when LB_PED_EXTEND_EN is defined.
interface light_board_ctrl_if;
    logic       enable;
    logic [1:0] mode;
`ifdef LB_PED_EXTEND_EN
    logic       ped_req;
`endif
    logic [1:0] mode_out;
    logic       busy;
    logic       done;
    logic [2:0] state_dbg;

    // Request: enable/mode are level inputs sampled every edge; there is no
    // ready -- busy high means a request is in flight, done pulses once when it ends.
`ifdef LB_PED_EXTEND_EN
    modport master (output enable, mode, ped_req, input mode_out, busy, done, state_dbg);
    modport slave  (input enable, mode, ped_req, output mode_out, busy, done, state_dbg);
`else
    modport master (output enable, mode, input mode_out, busy, done, state_dbg);
    modport slave  (input enable, mode, output mode_out, busy, done, state_dbg);
`endif
endinterface

// File: rtl/light_board_ctrl.sv
// Per-board light sequencer: normal GREEN->YELLOW cycle, flashing yellow, all-red hold.
// Optional pedestrian green extension enabled by defining LB_PED_EXTEND_EN.
module light_board_ctrl #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int FLASH_CYC  = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    light_board_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_FLASH  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_GREEN  = 2'd1;
    localparam logic [1:0] L_YELLOW = 2'd2;
    localparam logic [1:0] L_OFF    = 2'd3;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lamp_q, lamp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ext_q, ext_d;
    logic             ped;

`ifdef LB_PED_EXTEND_EN
    assign ped = bus.ped_req;
`else
    assign ped = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lamp_q  <= L_RED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lamp_q  <= lamp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ext_q   <= ext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lamp_d  = lamp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ext_d   = ext_q;
        unique case (state_q)
            S_IDLE: begin
                ext_d = 1'b0;
                // done_q high means the previous request just ended; skip one edge.
                if (bus.enable && !done_q) begin
                    unique case (bus.mode)
                        2'd0: begin
                            state_d = S_GREEN;
                            cnt_d   = GREEN_LD;
                            lamp_d  = L_GREEN;
                            busy_d  = 1'b1;
                        end
                        2'd1: begin
                            state_d = S_FLASH;
                            cnt_d   = FLASH_LD;
                            lamp_d  = L_YELLOW;
                            busy_d  = 1'b1;
                        end
                        2'd2: begin
                            state_d = S_HOLD;
                            lamp_d  = L_RED;
                            busy_d  = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_GREEN: begin
                if (cnt_q == '0) begin
                    state_d = S_YELLOW;
                    cnt_d   = YELLOW_LD;
                    lamp_d  = L_YELLOW;
                end else if (ped && !ext_q) begin
                    cnt_d = GREEN_LD;
                    ext_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    lamp_d  = L_RED;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ext_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FLASH: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    lamp_d  = L_RED;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    cnt_d  = FLASH_LD;
                    lamp_d = (lamp_q == L_YELLOW) ? L_OFF : L_YELLOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    lamp_d  = L_RED;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                lamp_d  = L_RED;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.mode_out  = lamp_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_light_board_ctrl.sv
// Bench for light_board_ctrl: each request is expanded by a sequence model into
// per-cycle stimulus and expected {mode_out,busy,done}; outputs checked at negedge.
module tb_light_board_ctrl;
    localparam int G = 8;
    localparam int Y = 3;
    localparam int F = 2;
    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] YEL = 2'd2;
    localparam logic [1:0] OFF = 2'd3;
`ifdef LB_PED_EXTEND_EN
    localparam bit EXT_ON = 1'b1;
`else
    localparam bit EXT_ON = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    light_board_ctrl_if bus ();

    light_board_ctrl #(
        .GREEN_CYC (G),
        .YELLOW_CYC(Y),
        .FLASH_CYC (F),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic       ped;
    } stim_t;

    stim_t      stim_q[$];
    logic [3:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pk(input logic [1:0] lamp, input logic b, input logic d);
        return {lamp, b, d};
    endfunction

    task automatic push(input logic en, input logic [1:0] md, input logic ped, input logic [3:0] e);
        stim_t s;
        s.en  = en;
        s.md  = md;
        s.ped = ped;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // scoreboard model: whole-request expansion from the sequence rules
    task automatic plan_normal(input int ped_at, input int ped_at2);
        int glen;
        int total;
        glen  = (EXT_ON && ped_at > 0 && ped_at < G) ? ped_at + G : G;
        total = glen + Y + 2;
        txn_id++;
        for (int i = 0; i < total; i++) begin
            logic       en;
            logic [1:0] md;
            logic       ped;
            logic [3:0] e;
            en  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            md  = (i == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            ped = (ped_at > 0 && i == ped_at) || (ped_at2 > 0 && i == ped_at2);
            if (i < glen)          e = pk(GRN, 1'b1, 1'b0);
            else if (i < glen + Y) e = pk(YEL, 1'b1, 1'b0);
            else if (i == glen + Y) e = pk(RED, 1'b0, 1'b1);
            else                   e = pk(RED, 1'b0, 1'b0);
            push(en, md, ped, e);
        end
    endtask

    task automatic plan_hold(input logic [1:0] mode, input int n);
        txn_id++;
        for (int i = 0; i < n; i++) begin
            logic [1:0] lamp;
            if (mode == 2'd1) lamp = (((i / F) % 2) != 0) ? OFF : YEL;
            else              lamp = RED;
            push(1'b1, (i == 0) ? mode : 2'($urandom_range(0, 3)), 1'b0, pk(lamp, 1'b1, 1'b0));
        end
        push(1'b0, 2'($urandom_range(0, 3)), 1'b0, pk(RED, 1'b0, 1'b1));
        push(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, pk(RED, 1'b0, 1'b0));
    endtask

    task automatic plan_reject();
        txn_id++;
        push(1'b1, 2'd3, 1'b0, pk(RED, 1'b0, 1'b1));
        push(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, pk(RED, 1'b0, 1'b0));
    endtask

    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 2'($urandom_range(0, 3)), 1'b0, pk(RED, 1'b0, 1'b0));
    endtask

    // driver: called at a negedge, drives one cycle and checks the result after the edge
    task automatic run_plan(input int max_cyc);
        int cyc;
        stim_t s;
        logic [3:0] e;
        cyc = 0;
        while (stim_q.size() > 0 && cyc < max_cyc) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            bus.enable = s.en;
            bus.mode   = s.md;
`ifdef LB_PED_EXTEND_EN
            bus.ped_req = s.ped;
`endif
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("t%0d_c%0d", txn_id, cyc), {bus.mode_out, bus.busy, bus.done}, e);
            cyc++;
        end
        stim_q.delete();
        exp_q.delete();
        bus.enable = 1'b0;
`ifdef LB_PED_EXTEND_EN
        bus.ped_req = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int p;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = 2'd0;
`ifdef LB_PED_EXTEND_EN
        bus.ped_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {bus.mode_out, bus.busy, bus.done}, pk(RED, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        plan_normal(0, 0);     run_plan(1000);
        plan_hold(2'd1, 9);    run_plan(1000);
        plan_hold(2'd2, 5);    run_plan(1000);
        plan_reject();         run_plan(1000);
        plan_hold(2'd1, 1);    run_plan(1000);

        // asynchronous reset in GREEN cycle 4
        plan_normal(0, 0);
        run_plan(4);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_now", {bus.mode_out, bus.busy, bus.done}, pk(RED, 1'b0, 1'b0));
        repeat (2) begin
            @(negedge clk);
            check_eq("reset_held", {bus.mode_out, bus.busy, bus.done}, pk(RED, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        plan_idle(2);          run_plan(1000);
        plan_normal(0, 0);     run_plan(1000);

`ifdef LB_PED_EXTEND_EN
        plan_normal(5, 7);     run_plan(1000);
        plan_normal(G, 0);     run_plan(1000);
        plan_normal(1, 0);     run_plan(1000);
`endif

        for (int t = 0; t < 14; t++) begin
            m = $urandom_range(0, 3);
            case (m)
                0: begin
                    p = EXT_ON ? $urandom_range(0, G) : 0;
                    plan_normal(p, (p > 0) ? p + 2 : 0);
                end
                1, 2: plan_hold(2'(m), $urandom_range(1, 12));
                default: plan_reject();
            endcase
            plan_idle($urandom_range(0, 2));
            run_plan(1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/light_board_ctrl.md
Name: light_board_ctrl

Overview:
- Per-board light sequencer. It is the receiving end of the timer's mode/board-select interface.
- The board-select decoder drives one one-hot line into `enable`. The timer's 2-bit mode code drives `mode`.
- The block runs the requested light sequence with internal counters and drives the board's lamp code on `mode_out`.
- It reports `busy` while running and pulses `done` on completion, so the timer can advance to the next board.

Parameters:
- GREEN_CYC, 8: cycles GREEN is shown in a normal sequence. Range 1..2^CNT_W.
- YELLOW_CYC, 3: cycles YELLOW is shown in a normal sequence. Range 1..2^CNT_W.
- FLASH_CYC, 2: half-period of flashing yellow, in cycles. Range 1..2^CNT_W.
- CNT_W, 8: width of the phase down-counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  board-select line from the decoder; high = this board is addressed.
- mode  input  2  requested mode: 0 normal cycle, 1 flashing yellow, 2 all-red hold, 3 reserved.
- mode_out  output  2  lamp code: 0 RED, 1 GREEN, 2 YELLOW, 3 OFF. Registered.
- busy  output  1  high while any non-IDLE state is active. Registered.
- done  output  1  one-cycle completion pulse. Registered.

Behaviour:
- Reset:
  - rst_n low forces IDLE immediately, regardless of clk or the current state.
  - Reset values: mode_out=0 (RED), busy=0, done=0, counter=0, extension flag clear.
  - Reset mid-sequence abandons the sequence; no done pulse is produced.
- States: IDLE, GREEN, YELLOW, FLASH, HOLD.
- IDLE:
  - mode_out=RED, busy=0.
  - enable is sampled every edge. On an edge with enable=1, mode is latched and the next state is selected:
    - mode 0 -> GREEN, counter loads GREEN_CYC-1.
    - mode 1 -> FLASH, counter loads FLASH_CYC-1, mode_out=YELLOW.
    - mode 2 -> HOLD.
    - mode 3 -> stay IDLE and pulse done on that edge (reject). busy never rises.
- Outputs update on the same edge that samples enable. The first GREEN/FLASH/HOLD cycle is the cycle following that edge.
- GREEN:
  - mode_out=GREEN, busy=1. Counter decrements each cycle.
  - Counter=0 -> YELLOW, counter loads YELLOW_CYC-1.
  - GREEN lasts exactly GREEN_CYC cycles.
- YELLOW:
  - mode_out=YELLOW, busy=1.
  - Counter=0 -> IDLE, with done=1 in the same cycle mode_out returns to RED.
  - YELLOW lasts exactly YELLOW_CYC cycles.
- FLASH:
  - busy=1. mode_out alternates YELLOW/OFF, toggling each time the counter reaches 0 (counter reloads FLASH_CYC-1).
  - Sampling enable=0 -> IDLE, RED, done pulse.
- HOLD:
  - mode_out=RED, busy=1.
  - Sampling enable=0 -> IDLE with done pulse.
- Changes to enable and mode are ignored during GREEN/YELLOW. A normal cycle always runs to completion.
- Changes to mode are ignored during FLASH/HOLD; only enable falling ends those states.
- done is high for exactly one cycle per completed or rejected request, never two consecutive cycles.
- enable=1 on the edge done is asserted does not start a new request. The block needs one IDLE cycle with done low before accepting again.
- Counter never wraps: it is reloaded before decrementing past 0.

Optional Feature:
- Macro: LB_PED_EXTEND_EN.
- Defined:
  - Adds input port `ped_req` (1 bit).
  - ped_req=1 sampled in GREEN with counter>0 and the extension flag clear reloads the counter to GREEN_CYC-1 and sets the flag.
  - Only one extension is allowed per normal cycle. The flag clears on entering IDLE.
  - ped_req on the same edge the counter is 0 is ignored.
- Undefined:
  - Port absent.
  - GREEN duration fixed at GREEN_CYC.

Test Plan:
- Reset, then enable=1 with mode=0 for one cycle:
  - mode_out = GREEN for 8 cycles, then YELLOW for 3 cycles, then RED.
  - done high exactly 1 cycle, coincident with the return to RED.
  - busy high for the 11 intervening cycles.
- enable=1 with mode=1 held 9 cycles, then dropped (FLASH_CYC=2):
  - mode_out pattern Y,Y,OFF,OFF,Y,Y,...
  - After enable falls: RED with a single done pulse.
- enable=1 with mode=2 held 5 cycles, then dropped:
  - mode_out RED throughout, busy=1 during hold.
  - done pulse on exit.
- enable=1 with mode=3:
  - busy stays 0, mode_out stays RED, done pulses 1 cycle.
- Start mode 0, assert rst_n=0 asynchronously at GREEN cycle 4:
  - mode_out=RED and busy=0 immediately; no done pulse.
  - After release, a fresh mode 0 request runs the full 8+3 sequence.
- With LB_PED_EXTEND_EN, start mode 0 and pulse ped_req at GREEN cycle 5, then again at cycle 7:
  - Total GREEN = 5+8 = 13 cycles; the second pulse is ignored.
  - YELLOW 3 cycles, then done.
